// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: issues 16-bit instruction-memory reads and feeds the IF/ID register.
// Handles decode stalls with a one-word hold buffer, redirect flushes (draining in-flight reads) and HALT.
module if_fetch_stage (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_rd,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        imem_done,
  input  logic        id_stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic [15:0] if_instr,
  output logic [15:0] if_pc2,
  output logic        if_valid,
  output logic        halted
);

  localparam logic [15:0] NOP = 16'h0800;

  typedef enum logic [1:0] {
    S_FETCH,
    S_HOLD,
    S_DRAIN,
    S_HALT
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] req_addr_q, req_addr_d;
  logic [15:0] hold_buf_q, hold_buf_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] pc2_q, pc2_d;
  logic        valid_q, valid_d;

  logic [15:0] redirect_tgt;
  logic [15:0] pc_plus2;
  logic        load;
  logic [15:0] load_word;

  function automatic logic is_halt(input logic [15:0] w);
    return (w[15:11] == 5'b00000);
  endfunction

  assign redirect_tgt = {redirect_pc[15:1], 1'b0};
  assign pc_plus2     = pc_q + 16'd2;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (redirect) begin
      // A read still in flight must complete before the new target is requested.
      if ((state_q == S_FETCH || state_q == S_DRAIN) && !imem_done) begin
        state_d = S_DRAIN;
      end else begin
        state_d = S_FETCH;
      end
    end else begin
      case (state_q)
        S_FETCH: begin
          if (imem_done) begin
            if (id_stall) begin
              state_d = S_HOLD;
            end else if (is_halt(imem_rdata)) begin
              state_d = S_HALT;
            end else begin
              state_d = S_FETCH;
            end
          end
        end
        S_HOLD: begin
          if (!id_stall) begin
            state_d = is_halt(hold_buf_q) ? S_HALT : S_FETCH;
          end
        end
        S_DRAIN: begin
          if (imem_done) begin
            state_d = S_FETCH;
          end
        end
        S_HALT:  state_d = S_HALT;
        default: state_d = S_FETCH;
      endcase
    end
  end

  // Outputs decoded from state
  always_comb begin
    imem_rd = 1'b0;
    halted  = 1'b0;
    case (state_q)
      S_FETCH: imem_rd = 1'b1;
      S_DRAIN: imem_rd = 1'b1;
      S_HALT:  halted  = 1'b1;
      default: ;
    endcase
  end

  assign imem_addr = req_addr_q;
  assign if_instr  = instr_q;
  assign if_pc2    = pc2_q;
  assign if_valid  = valid_q;

  // Datapath next-state
  always_comb begin
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    hold_buf_d = hold_buf_q;
    instr_d    = instr_q;
    pc2_d      = pc2_q;
    valid_d    = valid_q;
    load       = 1'b0;
    load_word  = imem_rdata;

    if (redirect) begin
      instr_d    = NOP;
      valid_d    = 1'b0;
      pc_d       = redirect_tgt;
      hold_buf_d = '0;
      if (state_d == S_FETCH) begin
        req_addr_d = redirect_tgt;
      end
    end else begin
      case (state_q)
        S_FETCH: begin
          if (imem_done && !id_stall) begin
            load      = 1'b1;
            load_word = imem_rdata;
          end else if (imem_done) begin
            hold_buf_d = imem_rdata;
          end else if (!id_stall) begin
            valid_d = 1'b0;
          end
        end
        S_HOLD: begin
          if (!id_stall) begin
            load      = 1'b1;
            load_word = hold_buf_q;
          end
        end
        S_DRAIN: begin
          if (imem_done) begin
            req_addr_d = pc_q;
          end
          if (!id_stall) begin
            valid_d = 1'b0;
          end
        end
        S_HALT: begin
          if (!id_stall) begin
            valid_d = 1'b0;
          end
        end
        default: ;
      endcase

      // Decode consumes an instruction once; a cycle without a new one is a bubble.
      if (load) begin
        instr_d = load_word;
        pc2_d   = pc_plus2;
        valid_d = 1'b1;
        if (!is_halt(load_word)) begin
          pc_d       = pc_plus2;
          req_addr_d = pc_plus2;
        end
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q       <= '0;
      req_addr_q <= '0;
      hold_buf_q <= '0;
      instr_q    <= NOP;
      pc2_q      <= '0;
      valid_q    <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      hold_buf_q <= hold_buf_d;
      instr_q    <= instr_d;
      pc2_q      <= pc2_d;
      valid_q    <= valid_d;
    end
  end

endmodule
